// File: rtl/cpu_pkg.sv
// Shared types for the ID-stage decode/issue controller: opcode map,
// registered control bundle layout and issue FSM states.
package cpu_pkg;

  localparam int OPC_W = 8;

  localparam logic [OPC_W-1:0] OP_ADD    = 8'h10;
  localparam logic [OPC_W-1:0] OP_ADDI   = 8'h11;
  localparam logic [OPC_W-1:0] OP_SUB    = 8'h12;
  localparam logic [OPC_W-1:0] OP_SUBI   = 8'h13;
  localparam logic [OPC_W-1:0] OP_MULTL  = 8'h14;
  localparam logic [OPC_W-1:0] OP_MULTLI = 8'h15;
  localparam logic [OPC_W-1:0] OP_MULTH  = 8'h16;
  localparam logic [OPC_W-1:0] OP_MULTHI = 8'h17;
  localparam logic [OPC_W-1:0] OP_SHL    = 8'h20;
  localparam logic [OPC_W-1:0] OP_SRAI   = 8'h25;
  localparam logic [OPC_W-1:0] OP_BEQ    = 8'h33;
  localparam logic [OPC_W-1:0] OP_BNE    = 8'h35;
  localparam logic [OPC_W-1:0] OP_BLT    = 8'h37;
  localparam logic [OPC_W-1:0] OP_BGE    = 8'h39;
  localparam logic [OPC_W-1:0] OP_BLTU   = 8'h3B;
  localparam logic [OPC_W-1:0] OP_JMP    = 8'h3D;
  localparam logic [OPC_W-1:0] OP_JMPI   = 8'h3F;
  localparam logic [OPC_W-1:0] OP_LDI    = 8'h81;
  localparam logic [OPC_W-1:0] OP_STI    = 8'h83;
  localparam logic [OPC_W-1:0] OP_LDB    = 8'h85;
  localparam logic [OPC_W-1:0] OP_STB    = 8'h87;

  typedef struct packed {
    logic [OPC_W-1:0] alu_op;
    logic             imm_src;
    logic             rf_we;
    logic             dm_we;
    logic             dm_re;
    logic             mem_src;
    logic             pc_src;
    logic             jmp_src;
    logic             err;
  } ctrl_t;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    BR   = 2'd2
  } state_t;

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational opcode decoder producing the control bundle plus the
// multi-cycle class flags the issue FSM needs.
module cpu_ctrl_decode
  import cpu_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output ctrl_t            ctrl,
  output logic             is_mul,
  output logic             is_ld
);

  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = opcode;
    is_mul      = 1'b0;
    is_ld       = 1'b0;
    case (opcode) inside
      [OP_ADD:OP_MULTHI], [OP_SHL:OP_SRAI]: begin
        ctrl.rf_we   = 1'b1;
        ctrl.imm_src = opcode[0];
        is_mul       = (opcode inside {[OP_MULTL:OP_MULTHI]});
      end
      OP_LDB, OP_LDI: begin
        ctrl.imm_src = 1'b1;
        ctrl.rf_we   = 1'b1;
        ctrl.dm_re   = 1'b1;
        ctrl.mem_src = 1'b1;
        is_ld        = 1'b1;
      end
      OP_STB, OP_STI: begin
        ctrl.imm_src = 1'b1;
        ctrl.dm_we   = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_JMP: begin
        ctrl.pc_src = 1'b1;
      end
      OP_JMPI: begin
        ctrl.pc_src  = 1'b1;
        ctrl.jmp_src = 1'b1;
      end
      default: ctrl.err = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl_issue.sv
// ID-stage issue controller: accepts instructions from fetch, registers the
// decoded bundle, and stalls fetch for multi-cycle ops and unresolved branches.
//   state | meaning
//   RUN   | accepting instructions
//   WAIT  | multi-cycle op in EX, counting down occupancy
//   BR    | branch/jump issued, waiting for br_resolve
module cpu_ctrl_issue
  import cpu_pkg::*;
#(
  parameter int INSTR_W    = 32,
  parameter int OP_W       = 8,
  parameter int OP_LSB     = 24,
  parameter int MUL_CYCLES = 3,
  parameter int LD_CYCLES  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic               flush,
  input  logic               br_resolve,
  input  logic               err_clr,
  output logic               ctrl_valid,
  output logic [OP_W-1:0]    alu_op,
  output logic               alu_imm_src,
  output logic               rf_write_en,
  output logic               datamem_write_en,
  output logic               datamem_read_en,
  output logic               rf_write_mem_src,
  output logic               pc_src,
  output logic               pc_jmp_src,
  output logic               err,
  output logic               err_sticky,
  output logic               ex_busy
);

  localparam int MAX_CYC = (MUL_CYCLES > LD_CYCLES) ? MUL_CYCLES : LD_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            dec, bundle_q;
  logic             is_mul, is_ld, accept, valid_q, sticky_q;
  logic [OPC_W-1:0] opcode;
  logic             unused_instr;

  assign opcode       = OPC_W'(instr[OP_LSB +: OP_W]);
  assign unused_instr = ^instr;

  cpu_ctrl_decode u_decode (
    .opcode (opcode),
    .ctrl   (dec),
    .is_mul (is_mul),
    .is_ld  (is_ld)
  );

  assign instr_ready = (state_q == RUN) & ~flush;
  assign accept      = instr_valid & instr_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = RUN;
      cnt_d   = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (accept) begin
            if (is_mul && (MUL_CYCLES > 1)) begin
              state_d = WAIT;
              cnt_d   = CNT_W'(MUL_CYCLES - 1);
            end else if (is_ld && (LD_CYCLES > 1)) begin
              state_d = WAIT;
              cnt_d   = CNT_W'(LD_CYCLES - 1);
            end else if (dec.pc_src) begin
              state_d = BR;
            end
          end
        end
        WAIT: begin
          if (cnt_q <= CNT_W'(1)) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        BR: begin
          if (br_resolve) state_d = RUN;
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      bundle_q <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= accept;
      if (accept) bundle_q <= dec;
      // a new error outranks a simultaneous clear
      if (accept && dec.err) sticky_q <= 1'b1;
      else if (err_clr)      sticky_q <= 1'b0;
    end
  end

  assign ctrl_valid       = valid_q;
  assign alu_op           = OP_W'(bundle_q.alu_op);
  assign alu_imm_src      = bundle_q.imm_src;
  assign rf_write_mem_src = bundle_q.mem_src;
  assign pc_jmp_src       = bundle_q.jmp_src;
  assign err              = bundle_q.err;
  assign rf_write_en      = valid_q & bundle_q.rf_we;
  assign datamem_write_en = valid_q & bundle_q.dm_we;
  assign datamem_read_en  = valid_q & bundle_q.dm_re;
  assign pc_src           = valid_q & bundle_q.pc_src;
  assign err_sticky       = sticky_q;
  assign ex_busy          = (state_q == WAIT);

endmodule
